// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its helpers.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   typedef logic [KEY_W-1:0] key_code_t;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      ONE,
      MULTI
   } frame_result_t;

   // Key code is row*4 + col, which is simply the two indices concatenated.
   function automatic key_code_t make_code(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key report seen by the control logic.
interface keypad_scanner_if;
   import keypad_pkg::*;

   logic [NUM_ROWS-1:0] rowIn;
   logic [NUM_COLS-1:0] colOut;
   key_code_t           keyOut;
   logic                keyValidOut;
   logic                keyHeldOut;

   modport master (
      input  rowIn,
      output colOut,
      output keyOut,
      output keyValidOut,
      output keyHeldOut
   );

   modport slave (
      output rowIn,
      input  colOut,
      input  keyOut,
      input  keyValidOut,
      input  keyHeldOut
   );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider emitting a one-cycle tick every CLK_FREQ/SCAN_RATE cycles.
module scan_tick_gen #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int SCAN_RATE = 1000
) (
   input  logic clkIn,
   input  logic rstIn,
   output logic tickOut
);

   localparam int TICK_DIV = CLK_FREQ / SCAN_RATE;
   localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             tick;

   always_comb begin
      tick    = (count_q == CNT_W'(TICK_DIV - 1));
      count_d = tick ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tickOut = tick;

endmodule

// File: rtl/keypad_scanner.sv
// Column-by-column keypad scan with frame-level debounce; reports one strobe per
// accepted single-key press and rejects multi-key (ghosting) frames.
module keypad_scanner #(
   parameter int CLK_FREQ        = 100_000_000,
   parameter int SCAN_RATE       = 1000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic             clkIn,
   input  logic             rstIn,
   keypad_scanner_if.master kpd
);
   import keypad_pkg::*;

   localparam int CNT_W = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);

   logic                tick;
   logic [NUM_ROWS-1:0] sync1_q;
   logic [NUM_ROWS-1:0] sync2_q;
   logic [1:0]          col_idx_q, col_idx_d;
   logic [1:0]          acc_cnt_q, acc_cnt_d;
   key_code_t           acc_code_q, acc_code_d;
   logic [1:0]          scan_cnt;
   key_code_t           scan_code;
   logic                frame_end;
   frame_result_t       frame_res;
   state_t              state_q, state_d;
   key_code_t           cand_q, cand_d;
   key_code_t           key_q, key_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_inc;
   logic                valid_q, valid_d;

   scan_tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .SCAN_RATE (SCAN_RATE)
   ) u_tick (
      .clkIn   (clkIn),
      .rstIn   (rstIn),
      .tickOut (tick)
   );

   // Column 0 starts a fresh frame, so the carried-in count is ignored there.
   always_comb begin
      col_idx_d  = col_idx_q;
      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      scan_cnt   = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
      scan_code  = (col_idx_q == 2'd0) ? '0 : acc_code_q;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (!sync2_q[r]) begin
            if (scan_cnt == 2'd0) begin
               scan_code = make_code(2'(r), col_idx_q);
            end
            if (scan_cnt != 2'd2) begin
               scan_cnt = scan_cnt + 2'd1;
            end
         end
      end
      frame_end = tick && (col_idx_q == 2'd3);
      if (tick) begin
         col_idx_d  = col_idx_q + 2'd1;
         acc_cnt_d  = scan_cnt;
         acc_code_d = scan_code;
      end
      frame_res = NONE;
      if (scan_cnt == 2'd1) begin
         frame_res = ONE;
      end else if (scan_cnt == 2'd2) begin
         frame_res = MULTI;
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      cnt_inc = cnt_q + CNT_W'(1);
      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (frame_res == ONE) begin
                  cand_d = scan_code;
                  cnt_d  = CNT_W'(1);
                  if (DEBOUNCE_FRAMES == 1) begin
                     state_d = HELD;
                     key_d   = scan_code;
                     valid_d = 1'b1;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (frame_res == ONE && scan_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     state_d = HELD;
                     key_d   = cand_q;
                     valid_d = 1'b1;
                  end
               end else if (frame_res == ONE) begin
                  cand_d = scan_code;
                  cnt_d  = CNT_W'(1);
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            HELD: begin
               if (frame_res == NONE) begin
                  if (DEBOUNCE_FRAMES == 1) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = RELEASE;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (frame_res == NONE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         col_idx_q  <= '0;
         acc_cnt_q  <= '0;
         acc_code_q <= '0;
         state_q    <= IDLE;
         cand_q     <= '0;
         key_q      <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         sync1_q    <= kpd.rowIn;
         sync2_q    <= sync1_q;
         col_idx_q  <= col_idx_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_code_q <= acc_code_d;
         state_q    <= state_d;
         cand_q     <= cand_d;
         key_q      <= key_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
      end
   end

   assign kpd.colOut      = ~(4'b0001 << col_idx_q);
   assign kpd.keyOut      = key_q;
   assign kpd.keyValidOut = valid_q;
   assign kpd.keyHeldOut  = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix pulls rows low
// for pressed keys on the currently driven column.
module tb_keypad_scanner;

   localparam int FRAME = 40;

   logic        clk;
   logic        rst;
   logic [15:0] pressed;
   logic [3:0]  row_drive;
   int          n_compared;
   int          n_mismatched;

   keypad_scanner_if kif();

   keypad_scanner #(
      .CLK_FREQ        (1000),
      .SCAN_RATE       (100),
      .DEBOUNCE_FRAMES (3)
   ) dut (
      .clkIn (clk),
      .rstIn (rst),
      .kpd   (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key (r,c) shorts row r to column c; bit index of pressed is r*4+c.
   always_comb begin
      row_drive = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !kif.colOut[c]) begin
               row_drive[r] = 1'b0;
            end
         end
      end
   end
   assign kif.rowIn = row_drive;

   task automatic run_frames(input int n, output int pulses, output int first_at);
      pulses   = 0;
      first_at = 0;
      for (int i = 1; i <= n * FRAME; i++) begin
         @(negedge clk);
         if (kif.keyValidOut === 1'b1) begin
            pulses++;
            if (first_at == 0) first_at = i;
         end
      end
   endtask

   task automatic test_reset();
      pressed = '0;
      rst     = 1'b1;
      repeat (3) @(negedge clk);
      n_compared += 4;
      if (kif.colOut !== 4'b1110) begin
         n_mismatched++;
         $display("[TB] FAIL reset_colOut: got %b, expected 1110", kif.colOut);
      end
      if (kif.keyOut !== 4'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_keyOut: got %0d, expected 0", kif.keyOut);
      end
      if (kif.keyValidOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_valid: got %b, expected 0", kif.keyValidOut);
      end
      if (kif.keyHeldOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_held: got %b, expected 0", kif.keyHeldOut);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan_rotation();
      logic [3:0] exp_col;
      int         pulses;
      pulses = 0;
      for (int i = 1; i <= 2 * FRAME; i++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((i / 10) % 4));
         n_compared++;
         if (kif.colOut !== exp_col) begin
            n_mismatched++;
            $display("[TB] FAIL scan_colOut cycle %0d: got %b, expected %b", i, kif.colOut, exp_col);
         end
         if (kif.keyValidOut === 1'b1) pulses++;
      end
      n_compared++;
      if (pulses !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL scan_no_pulse: got %0d pulses, expected 0", pulses);
      end
   endtask

   task automatic test_press_accept();
      int pulses, first_at;
      pressed = 16'h0001 << 6;
      run_frames(6, pulses, first_at);
      n_compared += 4;
      if (pulses !== 1) begin
         n_mismatched++;
         $display("[TB] FAIL press_pulse_count: got %0d, expected 1", pulses);
      end
      if (first_at !== 3 * FRAME) begin
         n_mismatched++;
         $display("[TB] FAIL press_pulse_cycle: got %0d, expected %0d", first_at, 3 * FRAME);
      end
      if (kif.keyOut !== 4'd6) begin
         n_mismatched++;
         $display("[TB] FAIL press_keyOut: got %0d, expected 6", kif.keyOut);
      end
      if (kif.keyHeldOut !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL press_held: got %b, expected 1", kif.keyHeldOut);
      end
   endtask

   task automatic test_short_press();
      int pulses, first_at, total;
      pressed = '0;
      run_frames(2, pulses, first_at);
      n_compared++;
      if (kif.keyHeldOut !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL release_2frames_held: got %b, expected 1", kif.keyHeldOut);
      end
      run_frames(1, pulses, first_at);
      n_compared++;
      if (kif.keyHeldOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL release_3frames_held: got %b, expected 0", kif.keyHeldOut);
      end
      pressed = 16'h0001 << 12;
      run_frames(2, pulses, first_at);
      total   = pulses;
      pressed = '0;
      run_frames(2, pulses, first_at);
      total += pulses;
      n_compared += 3;
      if (total !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL short_pulse_count: got %0d, expected 0", total);
      end
      if (kif.keyOut !== 4'd6) begin
         n_mismatched++;
         $display("[TB] FAIL short_keyOut: got %0d, expected 6", kif.keyOut);
      end
      if (kif.keyHeldOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL short_held: got %b, expected 0", kif.keyHeldOut);
      end
   endtask

   task automatic test_ghosting();
      int pulses, first_at;
      pressed = (16'h0001 << 0) | (16'h0001 << 11);
      run_frames(5, pulses, first_at);
      n_compared += 2;
      if (pulses !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL multi_pulse_count: got %0d, expected 0", pulses);
      end
      if (kif.keyHeldOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL multi_held: got %b, expected 0", kif.keyHeldOut);
      end
      pressed = 16'h0001;
      run_frames(3, pulses, first_at);
      n_compared += 3;
      if (pulses !== 1 || first_at !== 3 * FRAME) begin
         n_mismatched++;
         $display("[TB] FAIL single_after_multi_pulse: got %0d at %0d, expected 1 at %0d", pulses, first_at, 3 * FRAME);
      end
      if (kif.keyOut !== 4'd0) begin
         n_mismatched++;
         $display("[TB] FAIL single_after_multi_keyOut: got %0d, expected 0", kif.keyOut);
      end
      if (kif.keyHeldOut !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL single_after_multi_held: got %b, expected 1", kif.keyHeldOut);
      end
      pressed = '0;
      run_frames(3, pulses, first_at);
   endtask

   task automatic test_release_bounce();
      int pulses, first_at, total;
      pressed = 16'h0001 << 6;
      run_frames(3, pulses, first_at);
      total   = pulses;
      pressed = '0;
      run_frames(1, pulses, first_at);
      total += pulses;
      n_compared++;
      if (kif.keyHeldOut !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL bounce_gap_held: got %b, expected 1", kif.keyHeldOut);
      end
      pressed = 16'h0001 << 6;
      run_frames(2, pulses, first_at);
      total += pulses;
      n_compared += 3;
      if (total !== 1) begin
         n_mismatched++;
         $display("[TB] FAIL bounce_pulse_count: got %0d, expected 1", total);
      end
      if (kif.keyHeldOut !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL bounce_reheld: got %b, expected 1", kif.keyHeldOut);
      end
      if (kif.keyOut !== 4'd6) begin
         n_mismatched++;
         $display("[TB] FAIL bounce_keyOut: got %0d, expected 6", kif.keyOut);
      end
      pressed = '0;
      run_frames(3, pulses, first_at);
      n_compared++;
      if (kif.keyHeldOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL bounce_released_held: got %b, expected 0", kif.keyHeldOut);
      end
      pressed = 16'h0001 << 9;
      run_frames(3, pulses, first_at);
      n_compared += 2;
      if (pulses !== 1 || first_at !== 3 * FRAME) begin
         n_mismatched++;
         $display("[TB] FAIL fresh_press_pulse: got %0d at %0d, expected 1 at %0d", pulses, first_at, 3 * FRAME);
      end
      if (kif.keyOut !== 4'd9) begin
         n_mismatched++;
         $display("[TB] FAIL fresh_press_keyOut: got %0d, expected 9", kif.keyOut);
      end
      pressed = '0;
      run_frames(3, pulses, first_at);
   endtask

   task automatic test_reset_mid_debounce();
      int pulses, first_at;
      pressed = 16'h0001 << 5;
      run_frames(2, pulses, first_at);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      #1;
      n_compared += 4;
      if (kif.colOut !== 4'b1110) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_colOut: got %b, expected 1110", kif.colOut);
      end
      if (kif.keyOut !== 4'd0) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_keyOut: got %0d, expected 0", kif.keyOut);
      end
      if (kif.keyValidOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_valid: got %b, expected 0", kif.keyValidOut);
      end
      if (kif.keyHeldOut !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midrst_held: got %b, expected 0", kif.keyHeldOut);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_frames(2, pulses, first_at);
      n_compared++;
      if (pulses !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL postrst_early_pulse: got %0d, expected 0", pulses);
      end
      run_frames(1, pulses, first_at);
      n_compared += 3;
      if (pulses !== 1 || first_at !== FRAME) begin
         n_mismatched++;
         $display("[TB] FAIL postrst_pulse: got %0d at %0d, expected 1 at %0d", pulses, first_at, FRAME);
      end
      if (kif.keyOut !== 4'd5) begin
         n_mismatched++;
         $display("[TB] FAIL postrst_keyOut: got %0d, expected 5", kif.keyOut);
      end
      if (kif.keyHeldOut !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL postrst_held: got %b, expected 1", kif.keyHeldOut);
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst          = 1'b1;
      pressed      = '0;
      test_reset();
      test_scan_rotation();
      test_press_accept();
      test_short_press();
      test_ghosting();
      test_release_bounce();
      test_reset_mid_debounce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
